// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
package bit_serializer_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // Bit-counter width for a given word width (clog2, never below 1).
  function automatic int unsigned ser_cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock on dout, gapless across word boundaries.
//   clk, reset            : clock, synchronous active-high reset
//   data_in / data_valid  : parallel word and its valid
//   data_ready            : word accepted on this edge when data_valid=1
//   dout / dout_valid     : serial bit and its qualifier (IDLE_BIT when idle)
//   busy                  : a word is being shifted (equals dout_valid)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int unsigned          CNT_W    = ser_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             accept;

  always_comb begin
    if (MSB_FIRST) shifted = {shreg_q[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, shreg_q[WIDTH-1:1]};
  end

  assign last_bit   = (state_q == SER_SHIFT) && (cnt_q == CNT_LAST);
  // Ready on the last-bit cycle lets the next word follow with no bubble.
  assign data_ready = !reset && ((state_q == SER_IDLE) || last_bit);
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SER_SHIFT;
      shreg_d = data_in;
      cnt_d   = '0;
    end else if (state_q == SER_SHIFT) begin
      if (last_bit) begin
        state_d = SER_IDLE;
        cnt_d   = '0;
      end else begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // dout comes from registered state only; no path from data_in.
  assign busy       = (state_q == SER_SHIFT);
  assign dout_valid = busy;
  assign dout       = busy ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [7:0] data_in0 = '0, data_in1 = '0, data_in2 = '0;
  logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
  logic       ready0, ready1, ready2;
  logic       dout0, dout1, dout2;
  logic       dv0, dv1, dv2;
  logic       busy0, busy1, busy2;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in0), .data_valid(valid0),
    .data_ready(ready0), .dout(dout0), .dout_valid(dv0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in1), .data_valid(valid1),
    .data_ready(ready1), .dout(dout1), .dout_valid(dv1), .busy(busy1)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_idle1 (
    .clk(clk), .reset(reset), .data_in(data_in2), .data_valid(valid2),
    .data_ready(ready2), .dout(dout2), .dout_valid(dv2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds n words back-to-back into u_msb, checking every emitted bit and
  // the ready pulses. With noisy=1, data_in carries junk except at accept edges.
  task automatic run_words(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input int unsigned n, input bit noisy, output logic [23:0] seen);
    logic [7:0] words [2];
    logic [7:0] cur;
    int unsigned wi, bi;
    words[0] = w0;
    words[1] = w1;
    seen = '0;
    check({tag, " ready_idle"}, 32'(ready0), 32'd1);
    data_in0 = words[0];
    valid0   = 1'b1;
    tick();
    for (int unsigned k = 0; k < 8 * n; k++) begin
      wi  = k / 8;
      bi  = k % 8;
      cur = words[wi];
      check($sformatf("%s bit%0d", tag, k), 32'(dout0), 32'(cur[7 - bi]));
      check($sformatf("%s dv%0d", tag, k), 32'(dv0), 32'd1);
      check($sformatf("%s busy%0d", tag, k), 32'(busy0), 32'd1);
      check($sformatf("%s rdy%0d", tag, k), 32'(ready0), 32'(bi == 7));
      seen = {seen[22:0], dout0};
      if (bi == 7) begin
        if (wi + 1 < n) begin
          data_in0 = words[wi + 1];
        end else begin
          valid0   = 1'b0;
          data_in0 = 8'h5A ^ 8'(k);
        end
      end else if (noisy) begin
        data_in0 = 8'h5A ^ 8'(k);
      end else if (wi + 1 < n) begin
        data_in0 = words[wi + 1];
      end
      tick();
    end
    check({tag, " end_dout"}, 32'(dout0), 32'd0);
    check({tag, " end_dv"}, 32'(dv0), 32'd0);
    check({tag, " end_busy"}, 32'(busy0), 32'd0);
    check({tag, " end_ready"}, 32'(ready0), 32'd1);
  endtask

  initial begin
    logic [23:0] seen;
    int unsigned hits;

    // Reset state
    #1;
    check("rst ready0", 32'(ready0), 32'd0);
    check("rst ready2", 32'(ready2), 32'd0);
    tick();
    tick();
    check("rst dout0", 32'(dout0), 32'd0);
    check("rst dv0", 32'(dv0), 32'd0);
    check("rst busy0", 32'(busy0), 32'd0);
    check("rst dout2", 32'(dout2), 32'd1);
    check("rst dv2", 32'(dv2), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst ready0", 32'(ready0), 32'd1);

    // Single word, MSB first
    run_words("aa", 8'hAA, 8'h00, 1, 1'b0, seen);
    check("aa stream", 32'(seen[7:0]), 32'hAA);

    // Gapless back-to-back
    run_words("b2b", 8'hA8, 8'hFF, 2, 1'b0, seen);
    check("b2b stream", 32'(seen[15:0]), 32'hA8FF);

    // Pattern 101010 straddling the word boundary (0010_1010_1010_0000)
    run_words("det", 8'h2A, 8'hA0, 2, 1'b0, seen);
    hits = 0;
    for (int unsigned s = 0; s <= 10; s++)
      if (seen[15 - s -: 6] == 6'b101010) hits++;
    check("det hits", hits, 32'd3);

    // Backpressure: data_in changes every cycle while busy
    run_words("bp", 8'h3C, 8'hC5, 2, 1'b1, seen);
    check("bp stream", 32'(seen[15:0]), 32'h3CC5);

    // LSB first
    data_in1 = 8'h01;
    valid1   = 1'b1;
    check("lsb ready", 32'(ready1), 32'd1);
    tick();
    valid1   = 1'b0;
    data_in1 = 8'hFF;
    for (int unsigned k = 0; k < 8; k++) begin
      check($sformatf("lsb bit%0d", k), 32'(dout1), 32'(k == 0));
      check($sformatf("lsb dv%0d", k), 32'(dv1), 32'd1);
      tick();
    end
    check("lsb end_dv", 32'(dv1), 32'd0);
    check("lsb end_dout", 32'(dout1), 32'd0);

    // Reset mid-word after 3 bits of F0
    data_in0 = 8'hF0;
    valid0   = 1'b1;
    tick();
    valid0 = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      check($sformatf("mid bit%0d", k), 32'(dout0), 32'd1);
      if (k < 2) tick();
    end
    reset    = 1'b1;
    data_in0 = 8'h0F;
    valid0   = 1'b1;
    #1;
    check("mid rst_ready", 32'(ready0), 32'd0);
    tick();
    check("mid rst_dout", 32'(dout0), 32'd0);
    check("mid rst_dv", 32'(dv0), 32'd0);
    check("mid rst_busy", 32'(busy0), 32'd0);
    reset  = 1'b0;
    valid0 = 1'b0;
    #1;
    check("mid rel_ready", 32'(ready0), 32'd1);
    run_words("after_rst", 8'h0F, 8'h00, 1, 1'b0, seen);
    check("after_rst stream", 32'(seen[7:0]), 32'h0F);

    // IDLE_BIT=1, no traffic
    reset = 1'b1;
    #1;
    check("idle1 rst_ready", 32'(ready2), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int unsigned k = 0; k < 20; k++) begin
      check($sformatf("idle1 dout%0d", k), 32'(dout2), 32'd1);
      check($sformatf("idle1 dv%0d", k), 32'(dv2), 32'd0);
      check($sformatf("idle1 ready%0d", k), 32'(ready2), 32'd1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line, which drives the detector's din.
- Supports gapless back-to-back words, so a bit pattern can straddle a word boundary without a bubble.

Parameters:
- WIDTH, 8, word width in bits; must be at least 2.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- IDLE_BIT, 0, value driven on dout when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  block accepts data_in this cycle.
- dout  output  1  serial bit stream; connects to the detector's din.
- dout_valid  output  1  dout carries a data bit, not idle fill.
- busy  output  1  a word is currently being shifted.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values, sampled at the edge where reset=1:
  - state=IDLE, shift register cleared, bit counter=0.
  - dout=IDLE_BIT, dout_valid=0, busy=0.
  - data_ready is forced to 0 combinationally while reset=1.
- States: IDLE and SHIFT (2-state FSM), plus a bit counter cnt of width clog2(WIDTH) that counts bits already emitted.
- data_ready (combinational) = !reset && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)).
- Accept: data_valid && data_ready at a rising edge.
  - Word is loaded into the shift register; state=SHIFT; cnt=0.
- Latency: the first bit of an accepted word appears on dout in the cycle after the accept edge, with dout_valid=1.
  - Each following edge advances one bit.
  - WIDTH consecutive cycles of dout_valid=1 per word.
- Bit order:
  - MSB_FIRST=1: dout = shreg[WIDTH-1], shift left.
  - MSB_FIRST=0: dout = shreg[0], shift right.
  - dout is driven from a register, so there is no combinational path from data_in to dout.
- Last bit (cnt==WIDTH-1):
  - If a word is accepted on this edge, the new word's first bit follows immediately. There is no gap and dout_valid stays 1.
  - Otherwise state becomes IDLE, and dout=IDLE_BIT, dout_valid=0 from the next cycle.
- busy = (state==SHIFT); it equals dout_valid.
- data_valid held high while data_ready=0: no effect. data_in may change freely; only the value present at the accept edge is used.
- data_valid=0 in IDLE: outputs hold idle values indefinitely.
- Reset mid-word: the word in flight is discarded with no partial completion. Outputs are at reset values from the next cycle, and data_ready=1 in the first cycle after reset is released.
- The counter never exceeds WIDTH-1. No wrap beyond a word; cnt returns to 0 on each load.

Decomposition:
- Shared package bit_serializer_pkg:
  - typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
  - localparam helper for counter width (clog2 of WIDTH).
- Single module; no sub-module is warranted.
- Integration top (separate file) wires dout to the detector's din, sharing clk and reset.

Test Plan:
- WIDTH=8, MSB_FIRST=1: reset 2 cycles, then single accept of 8'hAA at edge T -> dout=1,0,1,0,1,0,1,0 on cycles T+1..T+8 with dout_valid=1 and busy=1; at T+9 dout=0, dout_valid=0, data_ready=1.
- Back-to-back: data_valid held high with 8'hA8 then 8'hFF -> the second accept happens at the last-bit edge of the first word; 16 contiguous valid bits 1010_1000_1111_1111 with no dout_valid gap.
  - Downstream detector fed with 8'h2A, 8'hA0 sees 101010 across the boundary.
- MSB_FIRST=0, 8'h01 -> dout sequence 1,0,0,0,0,0,0,0.
- Backpressure: data_valid=1 with data_in changing every cycle while busy -> only the values present at accept edges are serialized; data_ready pulses only on last-bit cycles.
- Reset asserted after 3 bits of 8'hF0 -> from the next cycle dout=IDLE_BIT, dout_valid=0, busy=0. After release, 8'h0F is accepted and shifted out in full as 0,0,0,0,1,1,1,1.
- IDLE_BIT=1, no traffic for 20 cycles -> dout=1, dout_valid=0 throughout; data_ready=1 except while reset=1.
